// File: rtl/exe_stage.sv
// Execute stage of the 5-stage LoongArch pipeline: latches the decoded
// instruction, runs the 12-op ALU, issues data-SRAM requests and forwards results.
module exe_stage #(
  parameter int DS_TO_ES_BUS_WD = 150,
  parameter int ES_TO_MS_BUS_WD = 71,
  parameter int ES_FWD_BUS_WD   = 39
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  logic                       es_valid_q, es_valid_d;
  logic [DS_TO_ES_BUS_WD-1:0] bus_q, bus_d;
  logic                       es_ready_go;
  logic                       fire;

  logic [11:0] alu_op;
  logic        res_from_mem, src1_is_pc, src2_is_imm, gr_we, mem_we;
  logic [4:0]  dest;
  logic [31:0] imm, rj_value, rkd_value, pc;
  logic [31:0] src1, src2, alu_result;
  logic [31:0] add_res, sub_res, slt_res, sltu_res;
  logic [31:0] sll_res, srl_res, sra_res;
  logic [4:0]  shamt;
  logic        dest_nz;

  assign es_ready_go    = 1'b1;
  assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid_q && es_ready_go;
  assign fire           = es_to_ms_valid && ms_allowin;

  always_comb begin
    es_valid_d = es_valid_q;
    bus_d      = bus_q;
    if (es_allowin) es_valid_d = ds_to_es_valid;
    if (ds_to_es_valid && es_allowin) bus_d = ds_to_es_bus;
  end

  // The instruction register is intentionally not reset: it is ignored while es_valid_q is low.
  always_ff @(posedge clk) begin
    if (reset) es_valid_q <= 1'b0;
    else       es_valid_q <= es_valid_d;
    bus_q <= bus_d;
  end

  assign {alu_op, res_from_mem, src1_is_pc, src2_is_imm, gr_we, mem_we,
          dest, imm, rj_value, rkd_value, pc} = bus_q;

  assign src1  = src1_is_pc  ? pc  : rj_value;
  assign src2  = src2_is_imm ? imm : rkd_value;
  assign shamt = src2[4:0];

  assign add_res  = src1 + src2;
  assign sub_res  = src1 - src2;
  assign slt_res  = {31'd0, $signed(src1) < $signed(src2)};
  assign sltu_res = {31'd0, src1 < src2};
  assign sll_res  = src1 << shamt;
  assign srl_res  = src1 >> shamt;
  assign sra_res  = $unsigned($signed(src1) >>> shamt);

  // One-hot select as an AND-OR mux so an all-zero op yields zero.
  always_comb begin
    alu_result = ({32{alu_op[0]}}  & add_res)
               | ({32{alu_op[1]}}  & sub_res)
               | ({32{alu_op[2]}}  & slt_res)
               | ({32{alu_op[3]}}  & sltu_res)
               | ({32{alu_op[4]}}  & (src1 & src2))
               | ({32{alu_op[5]}}  & ~(src1 | src2))
               | ({32{alu_op[6]}}  & (src1 | src2))
               | ({32{alu_op[7]}}  & (src1 ^ src2))
               | ({32{alu_op[8]}}  & sll_res)
               | ({32{alu_op[9]}}  & srl_res)
               | ({32{alu_op[10]}} & sra_res)
               | ({32{alu_op[11]}} & src2);
  end

  assign es_to_ms_bus = {res_from_mem, gr_we, dest, alu_result, pc};

  // Memory requests only on the hand-off cycle so a stalled store writes exactly once.
  assign data_sram_en    = fire && (res_from_mem || mem_we);
  assign data_sram_we    = (fire && mem_we) ? 4'hf : 4'h0;
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = rkd_value;

  assign dest_nz    = (dest != 5'd0);
  assign es_fwd_bus = {es_valid_q && gr_we && !res_from_mem && dest_nz,
                       es_valid_q && gr_we &&  res_from_mem && dest_nz,
                       dest, alu_result};

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage: reset, ALU ops, forwarding,
// load/store SRAM requests and stall behaviour.
module tb_exe_stage;

  localparam logic [11:0] OP_ADD  = 12'h001;
  localparam logic [11:0] OP_SUB  = 12'h002;
  localparam logic [11:0] OP_SLT  = 12'h004;
  localparam logic [11:0] OP_SLTU = 12'h008;
  localparam logic [11:0] OP_AND  = 12'h010;
  localparam logic [11:0] OP_NOR  = 12'h020;
  localparam logic [11:0] OP_OR   = 12'h040;
  localparam logic [11:0] OP_XOR  = 12'h080;
  localparam logic [11:0] OP_SLL  = 12'h100;
  localparam logic [11:0] OP_SRL  = 12'h200;
  localparam logic [11:0] OP_SRA  = 12'h400;
  localparam logic [11:0] OP_LUI  = 12'h800;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [149:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic [38:0]  es_fwd_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int vecCount = 0;
  int errCount = 0;

  exe_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ms_allowin      (ms_allowin),
    .es_allowin      (es_allowin),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .es_fwd_bus      (es_fwd_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [149:0] mk_bus(
    input logic [11:0] op, input logic rfm, input logic s1pc, input logic s2imm,
    input logic grwe, input logic memwe, input logic [4:0] dest,
    input logic [31:0] imm, input logic [31:0] rj, input logic [31:0] rkd,
    input logic [31:0] pc);
    return {op, rfm, s1pc, s2imm, grwe, memwe, dest, imm, rj, rkd, pc};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    ms_allowin     = 1'b1;
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = mk_bus(OP_ADD, 0, 0, 0, 1, 0, 5'd3, 32'd0, 32'd5, 32'd7, 32'h1c000000);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      vecCount++;
      if (es_to_ms_valid !== 1'b0) begin
        errCount++;
        $display("[TB] FAIL reset_valid cyc%0d actual=%b expected=0", i, es_to_ms_valid);
      end
      vecCount++;
      if (es_allowin !== 1'b1) begin
        errCount++;
        $display("[TB] FAIL reset_allowin cyc%0d actual=%b expected=1", i, es_allowin);
      end
      vecCount++;
      if ({data_sram_en, data_sram_we, es_fwd_bus[38:37]} !== 7'd0) begin
        errCount++;
        $display("[TB] FAIL reset_sram_fwd cyc%0d actual=%b expected=0",
                 i, {data_sram_en, data_sram_we, es_fwd_bus[38:37]});
      end
    end
    reset = 1'b0;
    #1;
    vecCount++;
    if (es_to_ms_valid !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL post_reset_early actual=%b expected=0", es_to_ms_valid);
    end
    next_cycle();
    vecCount++;
    if ({es_to_ms_valid, es_to_ms_bus[63:32]} !== {1'b1, 32'd12}) begin
      errCount++;
      $display("[TB] FAIL post_reset_first actual=%h expected=%h",
               {es_to_ms_valid, es_to_ms_bus[63:32]}, {1'b1, 32'd12});
    end
  endtask

  task automatic test_alu_ops();
    logic [11:0] ops  [13];
    logic [31:0] rjs  [13];
    logic [31:0] rks  [13];
    logic [31:0] exps [13];
    logic [31:0] pc;
    logic [70:0] expMs;
    logic [38:0] expFwd;
    ops[0]  = OP_ADD;  rjs[0]  = 32'd5;        rks[0]  = 32'd7;  exps[0]  = 32'd12;
    ops[1]  = OP_SUB;  rjs[1]  = 32'd3;        rks[1]  = 32'd5;  exps[1]  = 32'hFFFFFFFE;
    ops[2]  = OP_SLT;  rjs[2]  = 32'hFFFFFFFF; rks[2]  = 32'd1;  exps[2]  = 32'd1;
    ops[3]  = OP_SLTU; rjs[3]  = 32'hFFFFFFFF; rks[3]  = 32'd1;  exps[3]  = 32'd0;
    ops[4]  = OP_SRA;  rjs[4]  = 32'h80000000; rks[4]  = 32'd4;  exps[4]  = 32'hF8000000;
    ops[5]  = OP_NOR;  rjs[5]  = 32'd0;        rks[5]  = 32'd0;  exps[5]  = 32'hFFFFFFFF;
    ops[6]  = OP_AND;  rjs[6]  = 32'hF0F0;     rks[6]  = 32'hFF00; exps[6] = 32'hF000;
    ops[7]  = OP_OR;   rjs[7]  = 32'hF0F0;     rks[7]  = 32'hFF00; exps[7] = 32'hFFF0;
    ops[8]  = OP_XOR;  rjs[8]  = 32'hF0F0;     rks[8]  = 32'hFF00; exps[8] = 32'h0FF0;
    ops[9]  = OP_SLL;  rjs[9]  = 32'd1;        rks[9]  = 32'h21; exps[9]  = 32'd2;
    ops[10] = OP_SRL;  rjs[10] = 32'h80000000; rks[10] = 32'd31; exps[10] = 32'd1;
    ops[11] = OP_LUI;  rjs[11] = 32'hFFFFFFFF; rks[11] = 32'd9;  exps[11] = 32'h12345000;
    ops[12] = 12'h000; rjs[12] = 32'd5;        rks[12] = 32'd7;  exps[12] = 32'd0;
    for (int i = 0; i < 13; i++) begin
      pc = 32'h1c000100 + 32'(i * 4);
      ds_to_es_bus = mk_bus(ops[i], 0, 0, (i == 11), 1, 0, 5'd3, 32'h12345000,
                            rjs[i], rks[i], pc);
      next_cycle();
      expMs  = {1'b0, 1'b1, 5'd3, exps[i], pc};
      expFwd = {1'b1, 1'b0, 5'd3, exps[i]};
      vecCount++;
      if ({es_to_ms_valid, es_to_ms_bus} !== {1'b1, expMs}) begin
        errCount++;
        $display("[TB] FAIL alu_op%0d ms_bus actual=%h expected=%h",
                 i, {es_to_ms_valid, es_to_ms_bus}, {1'b1, expMs});
      end
      vecCount++;
      if (es_fwd_bus !== expFwd) begin
        errCount++;
        $display("[TB] FAIL alu_op%0d fwd actual=%h expected=%h", i, es_fwd_bus, expFwd);
      end
    end
  endtask

  task automatic test_jirl();
    ds_to_es_bus = mk_bus(OP_ADD, 0, 1, 1, 1, 0, 5'd1, 32'd4, 32'hAAAA0000,
                          32'h5555, 32'h1c000010);
    next_cycle();
    vecCount++;
    if (es_to_ms_bus[63:32] !== 32'h1c000014) begin
      errCount++;
      $display("[TB] FAIL jirl_result actual=%h expected=1c000014", es_to_ms_bus[63:32]);
    end
    vecCount++;
    if (es_fwd_bus !== {1'b1, 1'b0, 5'd1, 32'h1c000014}) begin
      errCount++;
      $display("[TB] FAIL jirl_fwd actual=%h expected=%h",
               es_fwd_bus, {1'b1, 1'b0, 5'd1, 32'h1c000014});
    end
  endtask

  task automatic test_store_stall();
    int enCount = 0;
    ds_to_es_bus = mk_bus(OP_ADD, 0, 0, 1, 0, 1, 5'd0, 32'd8, 32'h100,
                          32'hDEADBEEF, 32'h1c000020);
    next_cycle();
    ms_allowin     = 1'b0;
    ds_to_es_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      enCount += int'(data_sram_en);
      vecCount++;
      if ({data_sram_en, data_sram_we, es_allowin, es_to_ms_valid} !== 7'b0_0000_0_1) begin
        errCount++;
        $display("[TB] FAIL store_stall cyc%0d en/we/allowin/valid actual=%b expected=0000001",
                 i, {data_sram_en, data_sram_we, es_allowin, es_to_ms_valid});
      end
      next_cycle();
    end
    ms_allowin = 1'b1;
    #1;
    enCount += int'(data_sram_en);
    vecCount++;
    if ({data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata} !==
        {1'b1, 4'hf, 32'h108, 32'hDEADBEEF}) begin
      errCount++;
      $display("[TB] FAIL store_fire actual=%h expected=%h",
               {data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata},
               {1'b1, 4'hf, 32'h108, 32'hDEADBEEF});
    end
    next_cycle();
    enCount += int'(data_sram_en);
    vecCount++;
    if (enCount !== 1) begin
      errCount++;
      $display("[TB] FAIL store_once en_cycles actual=%0d expected=1", enCount);
    end
  endtask

  task automatic test_load_fwd();
    logic [4:0]  dests [3];
    logic        rfms  [3];
    logic        grwes [3];
    logic [1:0]  expFb [3];
    logic [4:0]  expSram [3];
    dests[0] = 5'd4; rfms[0] = 1'b1; grwes[0] = 1'b1; expFb[0] = 2'b01; expSram[0] = 5'b1_0000;
    dests[1] = 5'd0; rfms[1] = 1'b1; grwes[1] = 1'b1; expFb[1] = 2'b00; expSram[1] = 5'b1_0000;
    dests[2] = 5'd6; rfms[2] = 1'b0; grwes[2] = 1'b0; expFb[2] = 2'b00; expSram[2] = 5'b0_0000;
    ds_to_es_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ds_to_es_bus = mk_bus(OP_ADD, rfms[i], 0, 1, grwes[i], 0, dests[i], 32'd4,
                            32'h200, 32'd0, 32'h1c000030);
      next_cycle();
      vecCount++;
      if (es_fwd_bus[38:37] !== expFb[i]) begin
        errCount++;
        $display("[TB] FAIL load_fwd%0d fwd/blk actual=%b expected=%b",
                 i, es_fwd_bus[38:37], expFb[i]);
      end
      vecCount++;
      if ({data_sram_en, data_sram_we} !== expSram[i]) begin
        errCount++;
        $display("[TB] FAIL load_sram%0d en/we actual=%b expected=%b",
                 i, {data_sram_en, data_sram_we}, expSram[i]);
      end
    end
  endtask

  task automatic test_stall_hold();
    logic [70:0] expA, expB;
    logic [38:0] fwdA;
    ds_to_es_bus = mk_bus(OP_ADD, 0, 0, 0, 1, 0, 5'd7, 32'd0, 32'd1, 32'd2, 32'h1c000040);
    expA = {1'b0, 1'b1, 5'd7, 32'd3, 32'h1c000040};
    fwdA = {1'b1, 1'b0, 5'd7, 32'd3};
    next_cycle();
    ms_allowin   = 1'b0;
    ds_to_es_bus = mk_bus(OP_SUB, 0, 0, 0, 1, 0, 5'd9, 32'd0, 32'd10, 32'd4, 32'h1c000044);
    expB = {1'b0, 1'b1, 5'd9, 32'd6, 32'h1c000044};
    for (int i = 0; i < 3; i++) begin
      #1;
      vecCount++;
      if ({es_to_ms_bus, es_fwd_bus, es_allowin} !== {expA, fwdA, 1'b0}) begin
        errCount++;
        $display("[TB] FAIL stall_hold cyc%0d actual=%h expected=%h",
                 i, {es_to_ms_bus, es_fwd_bus, es_allowin}, {expA, fwdA, 1'b0});
      end
      next_cycle();
    end
    ms_allowin = 1'b1;
    #1;
    vecCount++;
    if ({es_allowin, es_to_ms_bus} !== {1'b1, expA}) begin
      errCount++;
      $display("[TB] FAIL stall_release actual=%h expected=%h",
               {es_allowin, es_to_ms_bus}, {1'b1, expA});
    end
    next_cycle();
    vecCount++;
    if ({es_to_ms_valid, es_to_ms_bus} !== {1'b1, expB}) begin
      errCount++;
      $display("[TB] FAIL stall_next actual=%h expected=%h",
               {es_to_ms_valid, es_to_ms_bus}, {1'b1, expB});
    end
  endtask

  initial begin
    reset          = 1'b1;
    ms_allowin     = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = '0;
    test_reset();
    test_alu_ops();
    test_jirl();
    test_store_stall();
    test_load_fwd();
    test_stall_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
